// File: rtl/stopwatch_pkg.sv
// Shared display constants and types for the stopwatch display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package stopwatch_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Slot number equals the anode bit it drives (slot 0 is rightmost).
    localparam logic [1:0] SLOT_TENTHS = 2'd0;
    localparam logic [1:0] SLOT_UNITS  = 2'd1;
    localparam logic [1:0] SLOT_TENS   = 2'd2;
    localparam logic [1:0] SLOT_MIN    = 2'd3;

    typedef struct packed {
        logic [3:0] minute;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
        logic [3:0] tenths;
    } bcd_time_t;

    function automatic logic is_zero_time(input bcd_time_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit common-anode scanner rendering M.SS.t with frame snapshot,
// anti-ghosting guard, leading-zero blanking and expiry blink.
module seven_seg_scanner
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter int GUARD_CYC     = 16,
    parameter int BLINK_DIV     = 25000000,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit_minute,
    input  logic [3:0] digit_sec_tens,
    input  logic [3:0] digit_sec_units,
    input  logic [3:0] digit_tenths,
    input  logic       running,
    input  logic       direction,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [1:0]    slot_idx;
    bcd_time_t     snapshot;
    logic [BW-1:0] blink_cnt;
    logic          blink_vis;

    logic          scan_wrap;
    logic          expired;
    logic [3:0]    digit_sel;
    logic [6:0]    digit_seg;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [3:0]    an_next;
    logic          blank_min;

    assign scan_wrap = (prescaler == PW'(SCAN_DIV - 1));
    assign expired   = !running && !direction && is_zero_time(snapshot);

    always_comb begin
        digit_sel = snapshot.tenths;
        case (slot_idx)
            SLOT_TENTHS: digit_sel = snapshot.tenths;
            SLOT_UNITS:  digit_sel = snapshot.sec_units;
            SLOT_TENS:   digit_sel = snapshot.sec_tens;
            SLOT_MIN:    digit_sel = snapshot.minute;
            default:     digit_sel = snapshot.tenths;
        endcase
    end

    bcd_to_7seg u_decoder (
        .bcd (digit_sel),
        .seg (digit_seg)
    );

    // Expiry forces the minute digit visible so a zero time reads 0.00.0.
    assign blank_min = (BLANK_LEADING != 0) && (slot_idx == SLOT_MIN)
                       && (snapshot.minute == 4'd0) && !expired;

    always_comb begin
        seg_next = digit_seg;
        dp_next  = !((slot_idx == SLOT_UNITS) || (slot_idx == SLOT_MIN));
        an_next  = 4'b1111;
        if (blank_min) begin
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end else if ((prescaler >= PW'(GUARD_CYC)) && !(expired && !blink_vis)) begin
            an_next = ~(4'b0001 << slot_idx);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prescaler <= '0;
            slot_idx  <= SLOT_TENTHS;
            snapshot  <= '0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            an        <= 4'b1111;
        end else begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;

            if (scan_wrap) begin
                prescaler <= '0;
                slot_idx  <= slot_idx + 2'd1;
                // Capturing only at frame start keeps one frame coherent.
                if (slot_idx == SLOT_MIN) begin
                    snapshot <= '{minute:    digit_minute,
                                  sec_tens:  digit_sec_tens,
                                  sec_units: digit_sec_units,
                                  tenths:    digit_tenths};
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            if (!expired) begin
                blink_cnt <= '0;
                blink_vis <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_vis <= !blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a time-based reference model predicts
// every registered output cycle; a monitor pops and compares independently.
module tb_seven_seg_scanner;

    localparam int SCAN_DIV  = 8;
    localparam int GUARD_CYC = 2;
    localparam int BLINK_DIV = 20;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit_minute = '0;
    logic [3:0] digit_sec_tens = '0;
    logic [3:0] digit_sec_units = '0;
    logic [3:0] digit_tenths = '0;
    logic       running = 1'b0;
    logic       direction = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    // Model state: cycles since reset release, consecutive expired cycles,
    // and the frame snapshot ([0]=tenths .. [3]=minute).
    int         mT = 0;
    int         mK = 0;
    logic [3:0] mSnap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    seven_seg_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .GUARD_CYC     (GUARD_CYC),
        .BLINK_DIV     (BLINK_DIV),
        .BLANK_LEADING (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .digit_minute    (digit_minute),
        .digit_sec_tens  (digit_sec_tens),
        .digit_sec_units (digit_sec_units),
        .digit_tenths    (digit_tenths),
        .running         (running),
        .direction       (direction),
        .seg             (seg),
        .dp              (dp),
        .an              (an)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] segFor(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit modelExpired(input logic run, input logic dir);
        return !run && !dir && mSnap[0] == 0 && mSnap[1] == 0
               && mSnap[2] == 0 && mSnap[3] == 0;
    endfunction

    function automatic exp_t computeExpected(input logic rst, input logic run, input logic dir);
        exp_t e;
        int   slot;
        int   phase;
        bit   expired;
        bit   vis;
        e.an  = 4'b1111;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (!rst) return e;
        slot    = (mT / SCAN_DIV) % 4;
        phase   = mT % SCAN_DIV;
        expired = modelExpired(run, dir);
        vis     = !expired || ((mK / BLINK_DIV) % 2 == 0);
        if (slot == 3 && mSnap[3] == 0 && !expired) return e;
        e.seg = segFor(mSnap[slot]);
        e.dp  = !(slot == 1 || slot == 3);
        if (phase >= GUARD_CYC && vis) e.an[slot] = 1'b0;
        return e;
    endfunction

    task automatic updateModel(input logic rst, input logic [3:0] m, input logic [3:0] st,
                               input logic [3:0] su, input logic [3:0] te,
                               input logic run, input logic dir);
        bit expired;
        if (!rst) begin
            mT = 0;
            mK = 0;
            for (int i = 0; i < 4; i++) mSnap[i] = 4'd0;
        end else begin
            expired = modelExpired(run, dir);
            if (mT % FRAME == FRAME - 1) begin
                mSnap[0] = te;
                mSnap[1] = su;
                mSnap[2] = st;
                mSnap[3] = m;
            end
            mK = expired ? mK + 1 : 0;
            mT++;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] m, input logic [3:0] st,
                                 input logic [3:0] su, input logic [3:0] te,
                                 input logic run, input logic dir, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset           = rst;
            digit_minute    = m;
            digit_sec_tens  = st;
            digit_sec_units = su;
            digit_tenths    = te;
            running         = run;
            direction       = dir;
            expQ.push_back(computeExpected(rst, run, dir));
            updateModel(rst, m, st, su, te, run, dir);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({an, seg, dp} !== e) begin
            errors++;
            $display("[TB] FAIL display t=%0t got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     $time, an, seg, dp, e.an, e.seg, e.dp);
        end
    endtask

    // Monitor: one registered output per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (done) break;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] rm, rst4, rsu, rte;
        logic       rrun, rdir;

        // Reset, then scan a frame of zeros, then 1:23.4 running.
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 2 * FRAME + 4);

        // Leading blank 0:05.7 and an invalid BCD seconds-tens digit.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 4'd7, 1'b1, 1'b1, 2 * FRAME);
        applyStimulus(1'b1, 4'd2, 4'hC, 4'd9, 4'd1, 1'b1, 1'b0, 2 * FRAME);

        // Tear-free: switch 1234 -> 5678 while slot 1 is lit.
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, FRAME);
        while (mT % FRAME != SCAN_DIV + 4)
            applyStimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 4'd5, 4'd6, 4'd7, 4'd8, 1'b1, 1'b1, 2 * FRAME);

        // Expiry blink, direction release, then reset in the middle of a blink.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 140);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 30);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 53);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 90);

        // Randomised traffic with occasional zero times, flag flips and resets.
        rm = 4'd3; rst4 = 4'd1; rsu = 4'd4; rte = 4'd1; rrun = 1'b1; rdir = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    rm = 4'd0; rst4 = 4'd0; rsu = 4'd0; rte = 4'd0;
                end else begin
                    rm   = 4'($urandom_range(0, 15));
                    rst4 = 4'($urandom_range(0, 15));
                    rsu  = 4'($urandom_range(0, 15));
                    rte  = 4'($urandom_range(0, 9));
                end
            end
            if ($urandom_range(0, 31) == 0) rrun = ~rrun;
            if ($urandom_range(0, 31) == 0) rdir = ~rdir;
            applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                          rm, rst4, rsu, rte, rrun, rdir, 1);
        end

        @(negedge clock);
        @(negedge clock);
        done = 1'b1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected outputs never compared, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
